// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one instruction in flight. It accepts an execute result,
// issues at most one valid/ready request on the data-memory port, aligns and
// extends load data, and presents exactly one result to writeback.
module ysyx_22040237_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [3:0]      ex_mem_op,
  input  logic [4:0]      ex_rd_idx,
  input  logic            ex_rd_wen,
  input  logic [XLEN-1:0] ex_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_rd_data,
  output logic [4:0]      wb_rd_idx,
  output logic            wb_rd_wen,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6;
  localparam logic [3:0] OP_LWU = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  state_t state;
  state_t next_state;

  logic [3:0]      op_q;
  logic [2:0]      off_q;
  logic            rd_wen_q;

  logic            ex_is_load;
  logic            ex_is_store;
  logic            ex_is_mem;
  logic [1:0]      ex_size;
  logic            ex_misalign;
  logic [2:0]      ex_off;
  logic [7:0]      ex_base_mask;
  logic            accept;

  logic            q_is_store;
  logic [XLEN-1:0] resp_shifted;
  logic [XLEN-1:0] load_data;

  assign ex_off = ex_result[2:0];
  assign accept = (state == IDLE) && ex_valid;

  // Decode the incoming op: class, access size (log2 bytes) and alignment fault
  always_comb begin
    ex_is_load   = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LWU);
    ex_is_store  = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SD);
    ex_is_mem    = ex_is_load || ex_is_store;
    ex_size      = 2'd3;
    ex_base_mask = 8'hFF;
    case (ex_mem_op)
      OP_LB, OP_LBU, OP_SB: begin
        ex_size      = 2'd0;
        ex_base_mask = 8'h01;
      end
      OP_LH, OP_LHU, OP_SH: begin
        ex_size      = 2'd1;
        ex_base_mask = 8'h03;
      end
      OP_LW, OP_LWU, OP_SW: begin
        ex_size      = 2'd2;
        ex_base_mask = 8'h0F;
      end
      default: begin
        ex_size      = 2'd3;
        ex_base_mask = 8'hFF;
      end
    endcase
    ex_misalign = 1'b0;
    case (ex_size)
      2'd1:    ex_misalign = ex_off[0];
      2'd2:    ex_misalign = |ex_off[1:0];
      2'd3:    ex_misalign = |ex_off;
      default: ex_misalign = 1'b0;
    endcase
    ex_misalign = ex_misalign && ex_is_mem;
  end

  // State register; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: non-memory and faulting ops skip the bus entirely
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_mem || ex_misalign) begin
            next_state = DONE;
          end else begin
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (wb_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ex_ready is held low during reset
  always_comb begin
    ex_ready      = (state == IDLE) && rst;
    mem_req_valid = (state == REQ);
    wb_valid      = (state == DONE);
  end

  // Remember the op context needed later to align the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= 4'd0;
      off_q    <= 3'd0;
      rd_wen_q <= 1'b0;
    end else if (accept) begin
      op_q     <= ex_mem_op;
      off_q    <= ex_off;
      rd_wen_q <= ex_rd_wen;
    end
  end

  // Request fields are captured once at accept so they stay stable until the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 8'h00;
    end else if (accept && ex_is_mem && !ex_misalign) begin
      mem_req_addr <= {ex_result[XLEN-1:3], 3'b000};
      mem_req_wen  <= ex_is_store;
      if (ex_is_store) begin
        mem_req_wdata <= ex_wdata << {ex_off, 3'b000};
        mem_req_wmask <= ex_base_mask << ex_off;
      end else begin
        mem_req_wdata <= '0;
        mem_req_wmask <= 8'h00;
      end
    end
  end

  assign q_is_store   = (op_q >= OP_SB) && (op_q <= OP_SD);
  assign resp_shifted = mem_resp_data >> {off_q, 3'b000};

  // Pick the addressed bytes out of the response and sign/zero extend them
  always_comb begin
    load_data = resp_shifted;
    case (op_q)
      OP_LB:   load_data = {{(XLEN-8){resp_shifted[7]}}, resp_shifted[7:0]};
      OP_LH:   load_data = {{(XLEN-16){resp_shifted[15]}}, resp_shifted[15:0]};
      OP_LW:   load_data = {{(XLEN-32){resp_shifted[31]}}, resp_shifted[31:0]};
      OP_LBU:  load_data = {{(XLEN-8){1'b0}}, resp_shifted[7:0]};
      OP_LHU:  load_data = {{(XLEN-16){1'b0}}, resp_shifted[15:0]};
      OP_LWU:  load_data = {{(XLEN-32){1'b0}}, resp_shifted[31:0]};
      OP_LD:   load_data = resp_shifted;
      default: load_data = resp_shifted;
    endcase
  end

  // Writeback result: filled at accept for ops that finish immediately, else at the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_rd_data  <= '0;
      wb_rd_idx   <= 5'd0;
      wb_rd_wen   <= 1'b0;
      wb_pc       <= '0;
      wb_misalign <= 1'b0;
    end else if (accept) begin
      wb_rd_idx <= ex_rd_idx;
      wb_pc     <= ex_pc;
      if (!ex_is_mem) begin
        wb_rd_data  <= ex_result;
        wb_rd_wen   <= ex_rd_wen;
        wb_misalign <= 1'b0;
      end else begin
        wb_rd_data  <= '0;
        wb_rd_wen   <= 1'b0;
        wb_misalign <= ex_misalign;
      end
    end else if ((state == RESP) && mem_resp_valid) begin
      if (q_is_store) begin
        wb_rd_data <= '0;
        wb_rd_wen  <= 1'b0;
      end else begin
        wb_rd_data <= load_data;
        wb_rd_wen  <= rd_wen_q;
      end
    end else if ((state == DONE) && wb_ready) begin
      wb_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Randomised self-checking bench for the load/store unit, with a byte-level
// reference model of address alignment, lane strobes and load extension.
module tb_ysyx_22040237_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_result;
  logic [63:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd_idx;
  logic        ex_rd_wen;
  logic [63:0] ex_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_rd_data;
  logic [4:0]  wb_rd_idx;
  logic        wb_rd_wen;
  logic [63:0] wb_pc;
  logic        wb_misalign;

  int checkCount = 0;
  int passCount  = 0;

  ysyx_22040237_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op), .ex_rd_idx(ex_rd_idx),
    .ex_rd_wen(ex_rd_wen), .ex_pc(ex_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_data(wb_rd_data),
    .wb_rd_idx(wb_rd_idx), .wb_rd_wen(wb_rd_wen), .wb_pc(wb_pc),
    .wb_misalign(wb_misalign)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes per op (0 for non-memory ops)
  function automatic int opBytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic bit opIsLoad(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

  function automatic bit opIsStore(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd11);
  endfunction

  function automatic bit opIsSigned(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd3);
  endfunction

  function automatic bit isMisaligned(input logic [3:0] op, input logic [63:0] addr);
    int n;
    n = opBytes(op);
    if (n == 0) return 1'b0;
    return (addr % n) != 0;
  endfunction

  function automatic logic [63:0] byteOf(input logic [63:0] word, input int idx);
    return (word >> (8 * idx)) & 64'hFF;
  endfunction

  // Gather the addressed bytes little-endian, then extend to 64 bits
  function automatic logic [63:0] expectLoad(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] resp);
    int n;
    int off;
    logic [63:0] v;
    n   = opBytes(op);
    off = int'(addr % 8);
    v   = 64'd0;
    for (int k = 0; k < n; k++) begin
      v = v + (byteOf(resp, off + k) << (8 * k));
    end
    if (opIsSigned(op) && (n < 8) && (((v >> (8 * n - 1)) & 64'd1) == 64'd1)) begin
      v = v - (64'd1 << (8 * n));
    end
    return v;
  endfunction

  function automatic logic [63:0] expectMask(input logic [3:0] op, input logic [63:0] addr);
    int n;
    int off;
    logic [63:0] m;
    n   = opBytes(op);
    off = int'(addr % 8);
    m   = 64'd0;
    if (opIsStore(op)) begin
      for (int k = 0; k < n; k++) begin
        m = m | (64'd1 << (off + k));
      end
    end
    return m;
  endfunction

  function automatic logic [63:0] expectWdata(input logic [63:0] addr, input logic [63:0] wdata);
    int off;
    logic [63:0] r;
    off = int'(addr % 8);
    r   = 64'd0;
    for (int lane = off; lane < 8; lane++) begin
      r = r | (byteOf(wdata, lane - off) << (8 * lane));
    end
    return r;
  endfunction

  // Run one full instruction through the unit, checking every cycle against the model
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] result, input logic [63:0] wdata,
                               input logic [4:0] rdIdx, input logic rdWen, input logic [63:0] pc,
                               input logic [63:0] resp, input int reqStall, input int respStall,
                               input int wbStall);
    bit isMem;
    bit mis;
    logic [63:0] expData;
    logic        expWen;
    isMem = opIsLoad(op) || opIsStore(op);
    mis   = isMisaligned(op, result);
    if (!isMem) begin
      expData = result;
      expWen  = rdWen;
    end else if (mis || opIsStore(op)) begin
      expData = 64'd0;
      expWen  = 1'b0;
    end else begin
      expData = expectLoad(op, result, resp);
      expWen  = rdWen;
    end

    checkOutput("ex_ready_idle", {63'd0, ex_ready}, 64'd1);
    ex_valid  = 1'b1;
    ex_mem_op = op;
    ex_result = result;
    ex_wdata  = wdata;
    ex_rd_idx = rdIdx;
    ex_rd_wen = rdWen;
    ex_pc     = pc;
    step();

    if (isMem && !mis) begin
      for (int c = 0; c <= reqStall; c++) begin
        ex_valid  = 1'($urandom_range(0, 1));
        ex_result = {$urandom, $urandom};
        ex_mem_op = 4'($urandom_range(0, 15));
        checkOutput("req_valid", {63'd0, mem_req_valid}, 64'd1);
        checkOutput("req_addr", mem_req_addr, result - (result % 8));
        checkOutput("req_wen", {63'd0, mem_req_wen}, {63'd0, opIsStore(op)});
        checkOutput("req_wmask", {56'd0, mem_req_wmask}, expectMask(op, result));
        if (opIsStore(op)) checkOutput("req_wdata", mem_req_wdata, expectWdata(result, wdata));
        checkOutput("ex_ready_busy", {63'd0, ex_ready}, 64'd0);
        checkOutput("wb_valid_req", {63'd0, wb_valid}, 64'd0);
        mem_req_ready = (c == reqStall);
        step();
      end
      mem_req_ready = 1'b0;
      for (int c = 0; c <= respStall; c++) begin
        checkOutput("req_dropped", {63'd0, mem_req_valid}, 64'd0);
        checkOutput("wb_valid_resp", {63'd0, wb_valid}, 64'd0);
        mem_resp_valid = (c == respStall);
        mem_resp_data  = (c == respStall) ? resp : {$urandom, $urandom};
        step();
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
    end

    for (int c = 0; c <= wbStall; c++) begin
      checkOutput("wb_valid", {63'd0, wb_valid}, 64'd1);
      checkOutput("wb_rd_idx", {59'd0, wb_rd_idx}, {59'd0, rdIdx});
      checkOutput("wb_rd_wen", {63'd0, wb_rd_wen}, {63'd0, expWen});
      checkOutput("wb_pc", wb_pc, pc);
      checkOutput("wb_misalign", {63'd0, wb_misalign}, {63'd0, mis});
      if (!mis) checkOutput("wb_rd_data", wb_rd_data, expData);
      checkOutput("ex_ready_done", {63'd0, ex_ready}, 64'd0);
      checkOutput("req_valid_done", {63'd0, mem_req_valid}, 64'd0);
      wb_ready = (c == wbStall);
      ex_valid = (c == wbStall) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end
    wb_ready = 1'b0;
    ex_valid = 1'b0;
    checkOutput("wb_valid_clear", {63'd0, wb_valid}, 64'd0);
    checkOutput("wb_misalign_clear", {63'd0, wb_misalign}, 64'd0);
    checkOutput("ex_ready_after", {63'd0, ex_ready}, 64'd1);
  endtask

  // Check that every output of the unit reads zero
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ex_ready"}, {63'd0, ex_ready}, 64'd0);
    checkOutput({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    checkOutput({tag, "_req_addr"}, mem_req_addr, 64'd0);
    checkOutput({tag, "_req_wen"}, {63'd0, mem_req_wen}, 64'd0);
    checkOutput({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
    checkOutput({tag, "_req_wmask"}, {56'd0, mem_req_wmask}, 64'd0);
    checkOutput({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    checkOutput({tag, "_wb_rd_data"}, wb_rd_data, 64'd0);
    checkOutput({tag, "_wb_rd_idx"}, {59'd0, wb_rd_idx}, 64'd0);
    checkOutput({tag, "_wb_rd_wen"}, {63'd0, wb_rd_wen}, 64'd0);
    checkOutput({tag, "_wb_pc"}, wb_pc, 64'd0);
    checkOutput({tag, "_wb_misalign"}, {63'd0, wb_misalign}, 64'd0);
  endtask

  // Main sequence: reset, directed cases, reset mid-transaction, then random traffic
  initial begin
    logic [3:0]  op;
    logic [63:0] addr;
    int          n;
    rst            = 1'b1;
    ex_valid       = 1'b0;
    ex_result      = 64'd0;
    ex_wdata       = 64'd0;
    ex_mem_op      = 4'd0;
    ex_rd_idx      = 5'd0;
    ex_rd_wen      = 1'b0;
    ex_pc          = 64'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'd0;
    wb_ready       = 1'b0;
    #1 rst = 1'b0;
    #2;
    checkAllZero("reset");
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("ex_ready_out_of_reset", {63'd0, ex_ready}, 64'd1);

    applyStimulus(4'd0, 64'h1234, 64'h5555, 5'd5, 1'b1, 64'h8000_0100, 64'd0, 0, 0, 0);
    applyStimulus(4'd1, 64'h8000_0003, 64'h0, 5'd6, 1'b1, 64'h8000_0104, 64'h0000_0000_8F00_0000, 0, 0, 0);
    applyStimulus(4'd5, 64'h8000_0003, 64'h0, 5'd7, 1'b1, 64'h8000_0108, 64'h0000_0000_8F00_0000, 0, 0, 0);
    applyStimulus(4'd9, 64'h8000_0006, 64'hABCD, 5'd8, 1'b1, 64'h8000_010C, 64'd0, 0, 0, 0);
    applyStimulus(4'd3, 64'h8000_0002, 64'h0, 5'd9, 1'b1, 64'h8000_0110, 64'd0, 0, 0, 0);
    applyStimulus(4'd4, 64'h8000_0008, 64'h0, 5'd10, 1'b1, 64'h8000_0114, 64'hDEAD_BEEF_0123_4567, 3, 2, 2);
    applyStimulus(4'd13, 64'hCAFE, 64'h0, 5'd11, 1'b0, 64'h8000_0118, 64'd0, 0, 0, 1);

    // Reset while the unit waits for a response
    ex_valid  = 1'b1;
    ex_mem_op = 4'd3;
    ex_result = 64'h8000_0010;
    ex_rd_idx = 5'd12;
    ex_rd_wen = 1'b1;
    ex_pc     = 64'h8000_0200;
    step();
    ex_valid      = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput("pre_reset_req_dropped", {63'd0, mem_req_valid}, 64'd0);
    #2 rst = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h1111_2222_3333_4444;
    step();
    mem_resp_valid = 1'b0;
    checkOutput("stale_resp_wb_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("stale_resp_ex_ready", {63'd0, ex_ready}, 64'd1);
    step();
    checkOutput("stale_resp_wb_valid2", {63'd0, wb_valid}, 64'd0);
    applyStimulus(4'd2, 64'h8000_0022, 64'h0, 5'd13, 1'b1, 64'h8000_0204, 64'h0000_0000_8001_0000, 1, 1, 0);

    for (int i = 0; i < 150; i++) begin
      op   = 4'($urandom_range(0, 15));
      addr = {$urandom, $urandom};
      n    = opBytes(op);
      if ((n > 0) && ($urandom_range(0, 3) != 0)) addr = addr - (addr % n);
      applyStimulus(op, addr, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_lsu.md
Name: ysyx_22040237_lsu

Overview:
- Load/store stage directly downstream of the execute unit.
- Consumes the execute result (ALU sum used as effective address or as a pass-through writeback value), store data and a memory-op code.
- Performs a multi-cycle valid/ready transaction on the data-memory port, aligns and extends load data, and hands one result per instruction to writeback.
- Non-pipelined: exactly one instruction in flight at a time.

Parameters:
XLEN, 64, datapath and address width; memory port data width equals XLEN (8 byte lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ex_valid  in  1  execute result valid
ex_ready  out  1  LSU can accept an instruction
ex_result  in  XLEN  execute result; effective address for memory ops, writeback value otherwise
ex_wdata  in  XLEN  store data (rs2)
ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 treated as NONE
ex_rd_idx  in  5  destination register
ex_rd_wen  in  1  destination write enable
ex_pc  in  XLEN  instruction PC, carried along
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  ex_result with bits [2:0] cleared
mem_req_wen  out  1  1 = store
mem_req_wdata  out  XLEN  store data shifted into lanes
mem_req_wmask  out  8  byte-lane strobes; 0 for loads
mem_resp_valid  in  1  response valid (load data or store ack)
mem_resp_data  in  XLEN  aligned 8-byte read data
wb_valid  out  1  result valid to writeback
wb_ready  in  1  writeback accepts
wb_rd_data  out  XLEN  final rd value
wb_rd_idx  out  5  destination register
wb_rd_wen  out  1  write enable (0 for stores and faults)
wb_pc  out  XLEN  PC of completing instruction
wb_misalign  out  1  misaligned access fault; no bus access was made

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All registered outputs 0: wb_valid, wb_rd_data, wb_rd_idx, wb_rd_wen, wb_pc, wb_misalign, mem_req_valid, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_addr. ex_ready=1 once out of reset.
- Reset asserted mid-transaction: return to IDLE immediately, dropping the transaction. A mem_resp_valid arriving while in IDLE is ignored.
- FSM states: IDLE, REQ, RESP, DONE. ex_ready=1 only in IDLE.
- IDLE, ex_valid=1: latch all ex_* inputs. off = ex_result[2:0].
  - NONE or reserved op -> DONE; wb_rd_data=ex_result, wb_rd_wen=ex_rd_wen.
  - Misaligned memory op -> DONE; wb_misalign=1, wb_rd_wen=0, no request issued. Misaligned means: H with off[0]!=0; W with off[1:0]!=0; D with off!=0. Byte ops never fault.
  - Otherwise -> REQ.
- REQ: mem_req_valid=1. addr/wen/wdata/wmask are stable until handshake.
  - Store: wmask = SB 8'h01<<off, SH 8'h03<<off, SW 8'h0F<<off, SD 8'hFF; wdata = ex_wdata<<(8*off).
  - On mem_req_valid & mem_req_ready: mem_req_valid=0, go to RESP.
- RESP: wait for mem_resp_valid; it is only sampled in this state. The earliest response is the cycle after the handshake.
  - Load: s = mem_resp_data>>(8*off), then take the low 8/16/32/64 bits. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU. Result to wb_rd_data, wb_rd_wen=ex_rd_wen.
  - Store: wb_rd_wen=0, wb_rd_data=0.
  - Go to DONE.
- DONE: wb_valid=1 with all wb_* held stable. On wb_ready=1, go to IDLE next cycle and clear wb_valid and wb_misalign.
- Latency from the ex_valid accept cycle N:
  - Non-memory or misaligned: wb_valid at N+1.
  - Memory op with mem_req_ready=1 and response one cycle later: handshake at N+1, resp at N+2, wb_valid at N+3.
  - Each stall cycle on mem_req_ready, mem_resp_valid or wb_ready adds one cycle.
- Back-to-back: the next instruction is accepted the cycle after the wb handshake. Max throughput is 1 instruction per 2 cycles.

Test Plan:
- Pass-through: ex_mem_op=0, ex_result=64'h1234, rd_idx=5, wen=1 -> wb_valid one cycle later; wb_rd_data=64'h1234, wb_rd_idx=5, wb_rd_wen=1, no mem_req_valid.
- Signed/unsigned byte load: addr 64'h8000_0003, mem_resp_data=64'h0000_0000_8F00_0000. LB -> wb_rd_data=64'hFFFF_FFFF_FFFF_FF8F; LBU -> 64'h8F; mem_req_addr=64'h8000_0000, wmask=0.
- Store lanes: SH addr 64'h8000_0006, ex_wdata=64'hABCD -> wmask=8'hC0, wdata=64'hABCD_0000_0000_0000, wen=1; after ack, wb_rd_wen=0.
- Misaligned: LW at 64'h8000_0002 -> wb_misalign=1, wb_rd_wen=0, wb_valid at N+1, mem_req_valid never 1.
- Backpressure: mem_req_ready low 3 cycles, response delayed 2 cycles, wb_ready low 2 cycles. Request fields and wb_* must stay stable throughout; LD of 64'hDEAD_BEEF_0123_4567 must return that value unmodified; ex_ready=0 until the cycle after the wb handshake.
- Reset in RESP: assert rst=0 while waiting for a response -> all outputs 0 immediately. A stale mem_resp_valid after release must produce no wb_valid; the next ex_valid is accepted normally.
